seg7_display_ctrl: RTL and testbench

// Multi-digit 7-segment display controller for the DE1-SoC HEX bank.

---
 rtl/seg7_pkg.sv | 30 +++
 rtl/seg7_glyph.sv | 33 +++
 rtl/seg7_display_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment display controller: active-low glyphs
// (gfedcba ordering) and the request FSM encoding.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0     = 7'h40;
  localparam logic [6:0] GLYPH_1     = 7'h79;
  localparam logic [6:0] GLYPH_2     = 7'h24;
  localparam logic [6:0] GLYPH_3     = 7'h30;
  localparam logic [6:0] GLYPH_4     = 7'h19;
  localparam logic [6:0] GLYPH_5     = 7'h12;
  localparam logic [6:0] GLYPH_6     = 7'h02;
  localparam logic [6:0] GLYPH_7     = 7'h78;
  localparam logic [6:0] GLYPH_8     = 7'h00;
  localparam logic [6:0] GLYPH_9     = 7'h10;
  localparam logic [6:0] GLYPH_A     = 7'h08;
  localparam logic [6:0] GLYPH_B     = 7'h03;
  localparam logic [6:0] GLYPH_C     = 7'h46;
  localparam logic [6:0] GLYPH_D     = 7'h21;
  localparam logic [6:0] GLYPH_E     = 7'h06;
  localparam logic [6:0] GLYPH_F     = 7'h0E;
  localparam logic [6:0] GLYPH_BLANK = 7'h7F;
  localparam logic [6:0] GLYPH_DASH  = 7'h3F;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_glyph.sv
// Combinational nibble to active-low 7-segment glyph decoder.
module seg7_glyph
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  // Glyph lookup for one digit.
  always_comb begin
    seg_o = GLYPH_BLANK;
    case (nibble_i)
      4'h0:    seg_o = GLYPH_0;
      4'h1:    seg_o = GLYPH_1;
      4'h2:    seg_o = GLYPH_2;
      4'h3:    seg_o = GLYPH_3;
      4'h4:    seg_o = GLYPH_4;
      4'h5:    seg_o = GLYPH_5;
      4'h6:    seg_o = GLYPH_6;
      4'h7:    seg_o = GLYPH_7;
      4'h8:    seg_o = GLYPH_8;
      4'h9:    seg_o = GLYPH_9;
      4'hA:    seg_o = GLYPH_A;
      4'hB:    seg_o = GLYPH_B;
      4'hC:    seg_o = GLYPH_C;
      4'hD:    seg_o = GLYPH_D;
      4'hE:    seg_o = GLYPH_E;
      4'hF:    seg_o = GLYPH_F;
      default: seg_o = GLYPH_BLANK;
    endcase
  end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Multi-digit 7-segment controller: captures a value over valid/ready, renders it as
// hex or decimal (serial double-dabble), with leading-zero blanking, overflow dashes and blink.
module seg7_display_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 6,
  parameter int DATA_W     = 24,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  input  logic                    in_dec,
  input  logic                    in_lzb,
  input  logic                    blink_en,
  output logic                    busy,
  output logic                    overflow,
  output logic [7*NUM_DIGITS-1:0] hex_out
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int HEX_W = 7 * NUM_DIGITS;
  localparam int EXT_W = (DATA_W > BCD_W) ? DATA_W : BCD_W;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int BLK_W = $clog2(BLINK_DIV);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);
  localparam logic [HEX_W-1:0] ALL_BLANK = {NUM_DIGITS{GLYPH_BLANK}};

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic               dec_q, dec_d;
  logic               lzb_q, lzb_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic               ovf_q, ovf_d;
  logic [HEX_W-1:0]   disp_q, disp_d;
  logic               overflow_q, overflow_d;
  logic [HEX_W-1:0]   hex_q, hex_d;
  logic [BLK_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic               phase_q, phase_d;

  logic [BCD_W-1:0]   adj_s;
  logic [EXT_W-1:0]   hex_ext_s;
  logic [HEX_W-1:0]   glyph_s;
  logic [HEX_W-1:0]   disp_new_s;

  assign hex_ext_s = EXT_W'(data_q);

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_glyph
    seg7_glyph u_glyph (
      .nibble_i (bcd_q[4*g +: 4]),
      .seg_o    (glyph_s[7*g +: 7])
    );
  end

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  always_comb begin
    adj_s = bcd_q;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        adj_s[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end else begin
        adj_s[4*k +: 4] = bcd_q[4*k +: 4];
      end
    end
  end

  // Digit selection for the commit: dashes on overflow, else blank above the top non-zero digit.
  always_comb begin
    logic seen;
    seen       = 1'b0;
    disp_new_s = ALL_BLANK;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if ((bcd_q[4*i +: 4] != 4'd0) || (i == 0)) begin
        seen = 1'b1;
      end else begin
        seen = seen;
      end
      if (ovf_q) begin
        disp_new_s[7*i +: 7] = GLYPH_DASH;
      end else if (lzb_q && !seen) begin
        disp_new_s[7*i +: 7] = GLYPH_BLANK;
      end else begin
        disp_new_s[7*i +: 7] = glyph_s[7*i +: 7];
      end
    end
  end

  // Request FSM, conversion datapath and display-register update.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    dec_d      = dec_q;
    lzb_d      = lzb_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    ovf_d      = ovf_q;
    disp_d     = disp_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          data_d  = in_data;
          dec_d   = in_dec;
          lzb_d   = in_lzb;
          cnt_d   = '0;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        if (dec_q) begin
          bcd_d  = {adj_s[BCD_W-2:0], data_q[DATA_W-1]};
          ovf_d  = ovf_q | adj_s[BCD_W-1];
          data_d = data_q << 1;
          if (cnt_q == LAST_BIT) begin
            state_d = COMMIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          bcd_d   = hex_ext_s[BCD_W-1:0];
          ovf_d   = |(hex_ext_s >> BCD_W);
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        disp_d     = disp_new_s;
        overflow_d = ovf_q;
        state_d    = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Free-running blink divider and the registered output mux.
  always_comb begin
    if (blink_cnt_q == BLK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else begin
      blink_cnt_d = blink_cnt_q + BLK_W'(1);
      phase_d     = phase_q;
    end
    if (blink_en && phase_q) begin
      hex_d = ALL_BLANK;
    end else begin
      hex_d = disp_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      data_q      <= '0;
      dec_q       <= 1'b0;
      lzb_q       <= 1'b0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      disp_q      <= ALL_BLANK;
      overflow_q  <= 1'b0;
      hex_q       <= ALL_BLANK;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      data_q      <= data_d;
      dec_q       <= dec_d;
      lzb_q       <= lzb_d;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      disp_q      <= disp_d;
      overflow_q  <= overflow_d;
      hex_q       <= hex_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign in_ready = (state_q == IDLE);
  assign busy     = (state_q != IDLE);
  assign overflow = overflow_q;
  assign hex_out  = hex_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Self-checking bench for seg7_display_ctrl: table vectors, random requests against
// an arithmetic reference model, and hand-written hold/reset/blink sequences.
module tb_seg7_display_ctrl;

  localparam int ND = 6;
  localparam int DW = 24;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   in_data = '0;
  logic            in_dec = 1'b0;
  logic            in_lzb = 1'b0;
  logic            blink_en = 1'b0;
  logic            busy;
  logic            overflow;
  logic [7*ND-1:0] hex_out;

  int n_vec = 0;
  int n_err = 0;
  logic [7*ND-1:0] prev_hex;

  localparam logic [41:0] BLANK6 = {6{7'h7F}};

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [23:0] v;
    logic        d;
    logic        z;
    logic [41:0] h;
    logic        o;
  } vec_t;

  vec_t tbl [9];

  seg7_display_ctrl #(.NUM_DIGITS(ND), .DATA_W(DW), .BLINK_DIV(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_dec   (in_dec),
    .in_lzb   (in_lzb),
    .blink_en (blink_en),
    .busy     (busy),
    .overflow (overflow),
    .hex_out  (hex_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // Reference: digits from plain division / nibble extraction, blanking from the top non-zero digit.
  function automatic void model(input logic [23:0] v, input logic d, input logic z,
                                output logic [41:0] h, output logic o);
    int unsigned x;
    int unsigned dig [6];
    int msd;
    x = v;
    if (d) begin
      o = (x >= 32'd1000000);
      for (int i = 0; i < 6; i++) begin
        dig[i] = x % 10;
        x = x / 10;
      end
    end else begin
      o = 1'b0;
      for (int i = 0; i < 6; i++) dig[i] = (x >> (4 * i)) & 32'hF;
    end
    msd = 0;
    for (int i = 0; i < 6; i++) if (dig[i] != 0) msd = i;
    for (int i = 0; i < 6; i++) begin
      if (o) h[7*i +: 7] = 7'h3F;
      else if (z && i > msd) h[7*i +: 7] = 7'h7F;
      else h[7*i +: 7] = glyph_tab[dig[i]];
    end
  endfunction

  task automatic wait_ready(input string nm, input int idx);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (in_ready !== 1'b1) chk({nm, "_ready_timeout"}, idx, 64'(in_ready), 64'd1);
  endtask

  task automatic run_req(input string nm, input int idx, input logic [23:0] v, input logic d,
                         input logic z, input logic [41:0] exp_h, input logic exp_o);
    int lat;
    wait_ready(nm, idx);
    @(negedge clk);
    in_valid = 1'b1; in_data = v; in_dec = d; in_lzb = z;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk({nm, "_busy"}, idx, 64'(busy), 64'd1);
    lat = d ? DW + 1 : 2;
    repeat (lat - 1) @(posedge clk);
    #1;
    chk({nm, "_hold"}, idx, 64'(hex_out), 64'(prev_hex));
    chk({nm, "_ready_early"}, idx, 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    chk({nm, "_hex"}, idx, 64'(hex_out), 64'(exp_h));
    chk({nm, "_ovf"}, idx, 64'(overflow), 64'(exp_o));
    chk({nm, "_ready"}, idx, 64'(in_ready), 64'd1);
    prev_hex = exp_h;
  endtask

  initial begin
    logic [41:0] mh;
    logic        mo;
    logic [23:0] rv;
    logic        rd, rz;
    logic        smp [16];
    int          nblank;

    tbl[0] = '{24'hABC123, 1'b0, 1'b0, {7'h08, 7'h03, 7'h46, 7'h79, 7'h24, 7'h30}, 1'b0};
    tbl[1] = '{24'd123456, 1'b1, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 1'b0};
    tbl[2] = '{24'd42,     1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0};
    tbl[3] = '{24'd0,      1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0};
    tbl[4] = '{24'd999999, 1'b1, 1'b0, {6{7'h10}}, 1'b0};
    tbl[5] = '{24'd1000000,1'b1, 1'b1, {6{7'h3F}}, 1'b1};
    tbl[6] = '{24'h000001, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h79}, 1'b0};
    tbl[7] = '{24'h000F00, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40}, 1'b0};
    tbl[8] = '{24'h000000, 1'b0, 1'b0, {6{7'h40}}, 1'b0};

    #12;
    chk("reset_hex", 0, 64'(hex_out), 64'(BLANK6));
    chk("reset_ready", 0, 64'(in_ready), 64'd1);
    chk("reset_busy", 0, 64'(busy), 64'd0);
    chk("reset_ovf", 0, 64'(overflow), 64'd0);
    prev_hex = BLANK6;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_req("table", i, tbl[i].v, tbl[i].d, tbl[i].z, tbl[i].h, tbl[i].o);

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      rz = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0:       rv = 24'($urandom_range(0, 99));
        1:       rv = 24'($urandom_range(0, 999999));
        2:       rv = 24'($urandom_range(999990, 1000010));
        default: rv = 24'($urandom);
      endcase
      model(rv, rd, rz, mh, mo);
      run_req("random", i, rv, rd, rz, mh, mo);
    end

    // in_valid held through the conversion with changing data: only the first value is taken.
    wait_ready("holdreq", 0);
    model(24'h00BEEF, 1'b0, 1'b1, mh, mo);
    @(negedge clk);
    in_valid = 1'b1; in_data = 24'h00BEEF; in_dec = 1'b0; in_lzb = 1'b1;
    @(posedge clk);
    #1;
    in_data = 24'h123456;
    @(posedge clk);
    #1;
    chk("holdreq_ready", 0, 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("holdreq_hex", 0, 64'(hex_out), 64'(mh));
    chk("holdreq_ready", 1, 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("holdreq_idle", 0, 64'(in_ready), 64'd1);
    chk("holdreq_hex", 1, 64'(hex_out), 64'(mh));
    prev_hex = mh;

    // Overflow committed, then reset in the middle of a decimal conversion.
    run_req("prerst", 0, 24'd5000000, 1'b1, 1'b0, {6{7'h3F}}, 1'b1);
    @(negedge clk);
    in_valid = 1'b1; in_data = 24'd777; in_dec = 1'b1; in_lzb = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_hex", 0, 64'(hex_out), 64'(BLANK6));
    chk("midrst_ready", 0, 64'(in_ready), 64'd1);
    chk("midrst_ovf", 0, 64'(overflow), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    prev_hex = BLANK6;
    repeat (30) @(posedge clk);
    #1;
    chk("midrst_discard", 0, 64'(hex_out), 64'(BLANK6));

    // Blink: shown/blank halves of 4 cycles each.
    run_req("blink_val", 0, 24'd31, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h79}, 1'b0);
    mh = {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h30, 7'h79};
    @(negedge clk);
    blink_en = 1'b1;
    @(posedge clk);
    nblank = 0;
    for (int k = 0; k < 16; k++) begin
      @(posedge clk);
      #1;
      smp[k] = (hex_out === BLANK6);
      if (smp[k]) nblank++;
      else chk("blink_shown", k, 64'(hex_out), 64'(mh));
    end
    chk("blink_count", 0, 64'(nblank), 64'd8);
    for (int k = 0; k < 12; k++) chk("blink_period", k, 64'(smp[k + 4]), 64'(!smp[k]));
    @(negedge clk);
    blink_en = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      chk("blink_off", k, 64'(hex_out), 64'(mh));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
